game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Central game-flow controller for the dinosaur runner.
- Owns the run/stop state, score, high score and scroll speed that drive the Jump, Ground and Cactus blocks.
- All state changes are committed once per frame, on the falling edge of vs, so sprites never change mid-scan.
- Replaces the ad-hoc game_status/trigger_start logic at top level.

Parameters:
- FRAMES_PER_POINT, 6: frames of running per score increment (>=1).
- POINTS_PER_SPEEDUP, 100: score increments between speed steps (>=1).
- SPEED_INIT, 2: speed loaded at every game start (4-bit).
- SPEED_MAX, 12: speed saturation value (4-bit, >= SPEED_INIT).
- DEATH_FRAMES, 60: frames start is ignored after a collision (>=1).
- SCORE_MAX, 9999: score saturation value (fits 14 bits).

Ports:
- CLK  in  1  system clock.
- clrn  in  1  asynchronous active-low reset.
- soft_rst  in  1  synchronous active-high game reset (debounced switch).
- vs  in  1  VGA vertical sync; a 1->0 transition marks a frame boundary.
- start  in  1  start request, level or pulse, already active-high.
- collision  in  1  px_dinosaur AND px_cactus, sampled every cycle.
- game_status  out  1  1 while in RUN.
- state  out  2  IDLE=0, RUN=1, DEAD=2, OVER=3.
- speed  out  4  scroll speed for Ground/Cactus.
- score  out  14  current score, binary.
- high_score  out  14  best score since clrn.
- frame_tick  out  1  one-cycle pulse on each vs falling edge.

Behaviour:
- Reset (clrn low, async): state=IDLE, game_status=0, speed=SPEED_INIT, score=0, high_score=0, frame_tick=0. All internal counters, vs_d (reset to 1) and latches cleared.
- frame_tick: registered. Asserted the cycle after vs_d=1 and vs=0 is sampled, which is a 1-cycle latency from the sampled edge.
- Latches, updated every cycle:
  - start_req sets when start=1.
  - hit sets when collision=1 in RUN.
  - Both are cleared only as stated below.
- State changes occur only in the cycle frame_tick=1, except soft_rst.
- IDLE: on tick with start_req -> RUN. Load score=0, speed=SPEED_INIT, frm_cnt=0, pt_cnt=0. Clear start_req and hit.
- RUN, on each tick:
  - If hit=1 -> DEAD. Load death_cnt=DEATH_FRAMES-1 and clear hit. If score>high_score, high_score<=score. No score increment this tick.
  - Otherwise frm_cnt increments. At FRAMES_PER_POINT-1 it wraps to 0 and a point is awarded.
  - Point: score+1, saturating at SCORE_MAX. pt_cnt increments; at POINTS_PER_SPEEDUP-1 it wraps to 0 and speed+1, saturating at SPEED_MAX.
  - At score saturation, pt_cnt and speed still advance.
  - start_req is cleared on every tick in RUN.
- DEAD: game_status=0; score and speed frozen. Each tick clears start_req. If death_cnt=0 -> OVER, else death_cnt-1. This gives exactly DEATH_FRAMES ticks in DEAD.
- OVER: score held for display. Tick with start_req behaves exactly as the IDLE start: -> RUN, same loads and clears. high_score is unchanged.
- Simultaneous start and collision in RUN: hit wins; start_req is discarded.
- Collision in IDLE, DEAD or OVER: ignored, hit stays 0.
- soft_rst=1 (synchronous, highest priority after clrn): state=IDLE, score=0, speed=SPEED_INIT, counters and latches cleared. high_score is retained. Works mid-run at any cycle, tick or not.
- game_status equals (state==RUN), registered.
- Arithmetic: counters are unsigned. Comparisons use widths sized from the parameters (clog2). No wrap is permitted on score or speed.

Test Plan:
- Reset release, then 3 frames with start=0 -> state=0, score=0, speed=2, frame_tick pulses 3 times, each 1 cycle wide.
- start pulsed mid-frame (FRAMES_PER_POINT=2) -> RUN entered exactly at the next tick; score=5 after 10 further ticks.
- POINTS_PER_SPEEDUP=3, SPEED_MAX=4, 24 points -> speed sequence 2,3,4 with step at score 3 and 6, then held at 4.
- Collision 1-cycle pulse mid-frame at score 7 -> DEAD at next tick, high_score=7; start held high throughout DEAD (DEATH_FRAMES=4) is ignored; OVER after 4 ticks.
- start in OVER -> RUN with score=0, speed=2, high_score still 7. Second death at score 3 -> high_score stays 7.
- soft_rst asserted mid-RUN between ticks -> IDLE next cycle, score=0, high_score kept. Also: start and collision in the same frame -> DEAD, not a restart.

Source files
------------

// File: rtl/game_sequencer.sv
// Game-flow controller: run/stop state, score, high score and scroll speed, committed once per frame.
// frame_tick lags the sampled vs fall by 1 cycle; state commits on the tick cycle; no backpressure, soft_rst acts immediately.
module game_sequencer #(
   parameter int FRAMES_PER_POINT   = 6,
   parameter int POINTS_PER_SPEEDUP = 100,
   parameter int SPEED_INIT         = 2,
   parameter int SPEED_MAX          = 12,
   parameter int DEATH_FRAMES       = 60,
   parameter int SCORE_MAX          = 9999
) (
   input  logic        CLK,
   input  logic        clrn,
   input  logic        soft_rst,
   input  logic        vs,
   input  logic        start,
   input  logic        collision,
   output logic        game_status,
   output logic [1:0]  state,
   output logic [3:0]  speed,
   output logic [13:0] score,
   output logic [13:0] high_score,
   output logic        frame_tick
);

   localparam int FC_W = (FRAMES_PER_POINT   > 1) ? $clog2(FRAMES_PER_POINT)   : 1;
   localparam int PC_W = (POINTS_PER_SPEEDUP > 1) ? $clog2(POINTS_PER_SPEEDUP) : 1;
   localparam int DC_W = (DEATH_FRAMES       > 1) ? $clog2(DEATH_FRAMES)       : 1;

   localparam logic [FC_W-1:0] FRM_LAST  = FC_W'(FRAMES_PER_POINT - 1);
   localparam logic [PC_W-1:0] PT_LAST   = PC_W'(POINTS_PER_SPEEDUP - 1);
   localparam logic [DC_W-1:0] DEATH_TOP = DC_W'(DEATH_FRAMES - 1);
   localparam logic [3:0]      SPD_INIT  = 4'(SPEED_INIT);
   localparam logic [3:0]      SPD_MAX   = 4'(SPEED_MAX);
   localparam logic [13:0]     SCR_MAX   = 14'(SCORE_MAX);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2, OVER = 2'd3} state_t;

   state_t          state_q, state_d;
   logic            vs_q;
   logic            tick_q, tick_d;
   logic            gs_q, gs_d;
   logic [3:0]      speed_q, speed_d;
   logic [13:0]     score_q, score_d;
   logic [13:0]     hs_q, hs_d;
   logic [FC_W-1:0] frm_cnt_q, frm_cnt_d;
   logic [PC_W-1:0] pt_cnt_q, pt_cnt_d;
   logic [DC_W-1:0] death_cnt_q, death_cnt_d;
   logic            start_req_q, start_req_d;
   logic            hit_q, hit_d;

   assign tick_d = vs_q & ~vs;

   always_ff @(posedge CLK or negedge clrn) begin
      if (!clrn) begin
         state_q     <= IDLE;
         vs_q        <= 1'b1;
         tick_q      <= 1'b0;
         gs_q        <= 1'b0;
         speed_q     <= SPD_INIT;
         score_q     <= '0;
         hs_q        <= '0;
         frm_cnt_q   <= '0;
         pt_cnt_q    <= '0;
         death_cnt_q <= '0;
         start_req_q <= 1'b0;
         hit_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         vs_q        <= vs;
         tick_q      <= tick_d;
         gs_q        <= gs_d;
         speed_q     <= speed_d;
         score_q     <= score_d;
         hs_q        <= hs_d;
         frm_cnt_q   <= frm_cnt_d;
         pt_cnt_q    <= pt_cnt_d;
         death_cnt_q <= death_cnt_d;
         start_req_q <= start_req_d;
         hit_q       <= hit_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      speed_d     = speed_q;
      score_d     = score_q;
      hs_d        = hs_q;
      frm_cnt_d   = frm_cnt_q;
      pt_cnt_d    = pt_cnt_q;
      death_cnt_d = death_cnt_q;
      start_req_d = start_req_q | start;
      hit_d       = hit_q | (collision && (state_q == RUN));

      if (tick_q) begin
         unique case (state_q)
            IDLE, OVER: begin
               if (start_req_q) begin
                  state_d     = RUN;
                  score_d     = '0;
                  speed_d     = SPD_INIT;
                  frm_cnt_d   = '0;
                  pt_cnt_d    = '0;
                  start_req_d = 1'b0;
                  hit_d       = 1'b0;
               end
            end
            RUN: begin
               start_req_d = 1'b0;
               if (hit_q) begin
                  state_d     = DEAD;
                  death_cnt_d = DEATH_TOP;
                  hit_d       = 1'b0;
                  if (score_q > hs_q) hs_d = score_q;
               end else if (frm_cnt_q != FRM_LAST) begin
                  frm_cnt_d = frm_cnt_q + 1'b1;
               end else begin
                  // point awarded; pt_cnt and speed keep advancing even once score is pinned
                  frm_cnt_d = '0;
                  if (score_q != SCR_MAX) score_d = score_q + 14'd1;
                  if (pt_cnt_q != PT_LAST) begin
                     pt_cnt_d = pt_cnt_q + 1'b1;
                  end else begin
                     pt_cnt_d = '0;
                     if (speed_q != SPD_MAX) speed_d = speed_q + 4'd1;
                  end
               end
            end
            DEAD: begin
               start_req_d = 1'b0;
               if (death_cnt_q == '0) state_d = OVER;
               else                   death_cnt_d = death_cnt_q - 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end

      if (soft_rst) begin
         state_d     = IDLE;
         score_d     = '0;
         speed_d     = SPD_INIT;
         frm_cnt_d   = '0;
         pt_cnt_d    = '0;
         death_cnt_d = '0;
         start_req_d = 1'b0;
         hit_d       = 1'b0;
      end

      gs_d = (state_d == RUN);
   end

   assign game_status = gs_q;
   assign state       = state_q;
   assign speed       = speed_q;
   assign score       = score_q;
   assign high_score  = hs_q;
   assign frame_tick  = tick_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: frame-by-frame directed stimulus, expected post-tick state queued and checked by a monitor.
module tb_game_sequencer;

   logic        CLK = 1'b0;
   logic        clrn = 1'b0;
   logic        soft_rst = 1'b0;
   logic        vs = 1'b1;
   logic        start = 1'b0;
   logic        collision = 1'b0;
   logic        game_status;
   logic [1:0]  state;
   logic [3:0]  speed;
   logic [13:0] score;
   logic [13:0] high_score;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;
   int ticks_seen = 0;
   int frames_sent = 0;
   bit start_hold = 1'b0;
   bit tick_prev = 1'b0;

   localparam int S_IDLE = 0, S_RUN = 1, S_DEAD = 2, S_OVER = 3;

   typedef struct packed {
      logic [1:0]  st;
      logic        gs;
      logic [3:0]  spd;
      logic [13:0] sc;
      logic [13:0] hs;
   } exp_t;

   exp_t exp_q[$];

   game_sequencer #(
      .FRAMES_PER_POINT(2), .POINTS_PER_SPEEDUP(3), .SPEED_INIT(2),
      .SPEED_MAX(4), .DEATH_FRAMES(4), .SCORE_MAX(9999)
   ) dut (
      .CLK(CLK), .clrn(clrn), .soft_rst(soft_rst), .vs(vs), .start(start),
      .collision(collision), .game_status(game_status), .state(state),
      .speed(speed), .score(score), .high_score(high_score), .frame_tick(frame_tick)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: the cycle after each frame_tick the committed state must match the queue head.
   always @(negedge CLK) begin
      if (clrn) begin
         if (tick_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL tick_unexpected: state=%0d score=%0d with nothing queued", state, score);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if ({state, game_status, speed, score, high_score} != e) begin
                  errors++;
                  $display("FAIL tick%0d: got st=%0d gs=%0d spd=%0d sc=%0d hs=%0d expected st=%0d gs=%0d spd=%0d sc=%0d hs=%0d",
                           ticks_seen, state, game_status, speed, score, high_score,
                           e.st, e.gs, e.spd, e.sc, e.hs);
               end
            end
            check("tick_width", int'(frame_tick), 0);
         end
         if (frame_tick) ticks_seen++;
         tick_prev = frame_tick;
      end
   end

   function automatic int spd_of(input int pts);
      int s;
      s = 2 + pts / 3;
      return (s > 4) ? 4 : s;
   endfunction

   // One frame: vs high 6 cycles (pulses at cycle 2), then low 4 cycles.
   task automatic frame(input int st, input int sc, input int sp, input int hs,
                        input bit sp_pulse, input bit co_pulse, input bit sr_pulse);
      exp_t e;
      e.st = 2'(st); e.gs = (st == S_RUN); e.spd = 4'(sp); e.sc = 14'(sc); e.hs = 14'(hs);
      exp_q.push_back(e);
      frames_sent++;
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         if (sr_pulse && c == 3) begin
            check("srst_state", int'(state), S_IDLE);
            check("srst_score", int'(score), 0);
            check("srst_speed", int'(speed), 2);
            check("srst_hs", int'(high_score), hs);
            check("srst_gs", int'(game_status), 0);
         end
         vs        = (c < 6);
         start     = start_hold | (sp_pulse && c == 2);
         collision = co_pulse && c == 2;
         soft_rst  = sr_pulse && c == 2;
      end
   endtask

   initial begin
      repeat (3) @(negedge CLK);
      check("rst_state", int'(state), S_IDLE);
      check("rst_gs", int'(game_status), 0);
      check("rst_speed", int'(speed), 2);
      check("rst_score", int'(score), 0);
      check("rst_hs", int'(high_score), 0);
      check("rst_tick", int'(frame_tick), 0);
      clrn = 1'b1;

      // idle frames
      for (int i = 0; i < 3; i++) frame(S_IDLE, 0, 2, 0, 0, 0, 0);
      check("idle_ticks", ticks_seen, 3);

      // game 1: start mid-frame, 14 ticks to score 7, collision
      frame(S_RUN, 0, 2, 0, 1, 0, 0);
      for (int k = 1; k <= 14; k++) frame(S_RUN, k / 2, spd_of(k / 2), 0, 0, 0, 0);
      frame(S_DEAD, 7, 4, 7, 0, 1, 0);
      start_hold = 1'b1;
      for (int k = 0; k < 3; k++) frame(S_DEAD, 7, 4, 7, 0, 0, 0);
      start_hold = 1'b0;
      frame(S_OVER, 7, 4, 7, 0, 0, 0);
      frame(S_OVER, 7, 4, 7, 0, 0, 0);

      // game 2: restart from OVER, die at score 3
      frame(S_RUN, 0, 2, 7, 1, 0, 0);
      for (int k = 1; k <= 6; k++) frame(S_RUN, k / 2, spd_of(k / 2), 7, 0, 0, 0);
      frame(S_DEAD, 3, 3, 7, 0, 1, 0);
      for (int k = 0; k < 3; k++) frame(S_DEAD, 3, 3, 7, 0, 0, 0);
      frame(S_OVER, 3, 3, 7, 0, 0, 0);

      // game 3: 24 points, speed saturates; start+collision in the same frame
      frame(S_RUN, 0, 2, 7, 1, 0, 0);
      for (int k = 1; k <= 48; k++) frame(S_RUN, k / 2, spd_of(k / 2), 7, 0, 0, 0);
      frame(S_DEAD, 24, 4, 24, 1, 1, 0);
      for (int k = 0; k < 3; k++) frame(S_DEAD, 24, 4, 24, 0, 0, 0);
      frame(S_OVER, 24, 4, 24, 0, 0, 0);
      frame(S_OVER, 24, 4, 24, 0, 0, 0);

      // game 4: soft reset mid-run keeps high score
      frame(S_RUN, 0, 2, 24, 1, 0, 0);
      for (int k = 1; k <= 4; k++) frame(S_RUN, k / 2, 2, 24, 0, 0, 0);
      frame(S_IDLE, 0, 2, 24, 0, 0, 1);
      frame(S_RUN, 0, 2, 24, 1, 0, 0);
      frame(S_RUN, 0, 2, 24, 0, 0, 0);
      frame(S_RUN, 1, 2, 24, 0, 0, 0);

      repeat (5) @(negedge CLK);
      check("queue_drained", exp_q.size(), 0);
      check("tick_count", ticks_seen, frames_sent);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
